// File: rtl/oam_dma_pkg.sv
// Shared types and constants for the sprite-DMA controller and its CPU-cycle timebase.
package oam_dma_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHalt,
    StAlign,
    StRead,
    StWrite
  } dma_state_type;

  localparam logic [15:0] TriggerAddrDefault = 16'h4014;
  localparam logic [15:0] DestAddrDefault    = 16'h2004;
  localparam int unsigned TicksDefault       = 12;
  localparam int unsigned TickWidth          = 4;

endpackage

// File: rtl/oam_dma_if.sv
// Core-side bus bundle: core outputs and read data in, muxed bus outputs back out.
interface oam_dma_if;
  logic [15:0] I_cpu_addr;
  logic [7:0]  I_cpu_wr_data;
  logic        I_cpu_rdwr;
  logic [7:0]  I_rd_data;
  logic [15:0] O_addr;
  logic [7:0]  O_wr_data;
  logic        O_rdwr;

  modport slave (
    input  I_cpu_addr,
    input  I_cpu_wr_data,
    input  I_cpu_rdwr,
    input  I_rd_data,
    output O_addr,
    output O_wr_data,
    output O_rdwr
  );

  modport master (
    output I_cpu_addr,
    output I_cpu_wr_data,
    output I_cpu_rdwr,
    output I_rd_data,
    input  O_addr,
    input  O_wr_data,
    input  O_rdwr
  );
endinterface

// File: rtl/cpu_timebase.sv
// Free-running CPU-cycle timebase: master-tick counter, phase-2, cycle strobe and get/put parity.
module cpu_timebase
  import oam_dma_pkg::*;
#(
  parameter int unsigned P_TICKS = TicksDefault
) (
  input  logic I_clock,
  input  logic I_reset,
  output logic O_cyc,
  output logic O_phy2,
  output logic O_parity
);

  localparam logic [TickWidth-1:0] TickLast = TickWidth'(P_TICKS - 1);
  localparam logic [TickWidth-1:0] TickHalf = TickWidth'(P_TICKS / 2);

  logic [TickWidth-1:0] tick_q, tick_d;
  logic                 parity_q, parity_d;

  assign O_cyc    = (tick_q == '0);
  assign O_phy2   = (tick_q >= TickHalf);
  assign O_parity = parity_q;

  always_comb begin
    tick_d   = (tick_q == TickLast) ? '0 : tick_q + TickWidth'(1);
    parity_d = O_cyc ? ~parity_q : parity_q;
  end

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      tick_q   <= '0;
      parity_q <= 1'b0;
    end else begin
      tick_q   <= tick_d;
      parity_q <= parity_d;
    end
  end

endmodule

// File: rtl/oam_dma.sv
// Sprite-DMA controller: snoops the trigger write, stalls the core and copies one page
// to the sprite data port with get/put-aligned read/write cycles.
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter logic [15:0] P_TRIGGER_ADDR = TriggerAddrDefault,
  parameter logic [15:0] P_DEST_ADDR    = DestAddrDefault,
  parameter int unsigned P_TICKS        = TicksDefault
) (
  input  logic       I_clock,
  input  logic       I_reset,
  oam_dma_if.slave   bus,
  output logic       O_ready,
  output logic       O_phy2,
  output logic       O_busy
);

  logic cyc;
  logic parity;

  cpu_timebase #(
    .P_TICKS (P_TICKS)
  ) u_timebase (
    .I_clock  (I_clock),
    .I_reset  (I_reset),
    .O_cyc    (cyc),
    .O_phy2   (O_phy2),
    .O_parity (parity)
  );

  dma_state_type state_q, state_d;
  logic [7:0]    page_q, page_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    buf_q, buf_d;
  logic          ready_q;

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    unique case (state_q)
      StIdle: begin
        if (bus.I_cpu_addr == P_TRIGGER_ADDR && !bus.I_cpu_rdwr) begin
          page_d  = bus.I_cpu_wr_data;
          cnt_d   = 8'd0;
          state_d = StHalt;
        end
      end
      // Reads must land on get cycles; burn one extra cycle if the next one is a put.
      StHalt:  state_d = parity ? StRead : StAlign;
      StAlign: state_d = StRead;
      StRead: begin
        buf_d   = bus.I_rd_data;
        state_d = StWrite;
      end
      StWrite: begin
        if (cnt_q == 8'hFF) begin
          state_d = StIdle;
        end else begin
          cnt_d   = cnt_q + 8'd1;
          state_d = StRead;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      state_q <= StIdle;
      page_q  <= 8'd0;
      cnt_q   <= 8'd0;
      buf_q   <= 8'd0;
      ready_q <= 1'b1;
    end else if (cyc) begin
      state_q <= state_d;
      page_q  <= page_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      ready_q <= (state_d == StIdle);
    end
  end

  always_comb begin
    bus.O_addr    = bus.I_cpu_addr;
    bus.O_wr_data = bus.I_cpu_wr_data;
    bus.O_rdwr    = bus.I_cpu_rdwr;
    unique case (state_q)
      StIdle: ;
      // Dummy read: a stalled core's pending write must not reach the bus.
      StHalt, StAlign: bus.O_rdwr = 1'b1;
      StRead: begin
        bus.O_addr = {page_q, cnt_q};
        bus.O_rdwr = 1'b1;
      end
      StWrite: begin
        bus.O_addr    = P_DEST_ADDR;
        bus.O_wr_data = buf_q;
        bus.O_rdwr    = 1'b0;
      end
      default: ;
    endcase
  end

  assign O_ready = ready_q;
  assign O_busy  = ~ready_q;

endmodule

// File: doc/oam_dma.md
# oam_dma

Sprite-DMA controller between the 6502 core and the system bus. It snoops core bus cycles for a write to the trigger register, then stalls the core through its ready input. While the core is stalled it owns the bus and copies one 256-byte page to the sprite data port with 2A03-accurate cycle counts. It also carries the free-running CPU-cycle timebase, because the core's own divider freezes while ready is low.

## Interface
- P_TRIGGER_ADDR, 16'h4014, write address that starts a transfer; the data byte is the source page.
- P_DEST_ADDR, 16'h2004, destination port written for every byte.
- P_TICKS, 12, master clocks per CPU cycle.
- I_clock  in  1  master clock.
- I_reset  in  1  reset, asynchronous, active-low.
- I_cpu_addr  in  16  core address output.
- I_cpu_wr_data  in  8  core write data.
- I_cpu_rdwr  in  1  core direction; 1 = read, 0 = write.
- I_rd_data  in  8  bus read data. It also feeds the core directly.
- O_addr  out  16  muxed bus address.
- O_wr_data  out  8  muxed bus write data.
- O_rdwr  out  1  muxed bus direction.
- O_ready  out  1  to core I_ready; 0 stalls the core.
- O_phy2  out  1  free-running phase-2; 1 when tick ≥ P_TICKS/2.
- O_busy  out  1  1 while state ≠ IDLE.

## Operation
- **Timebase**
  - tick counts 0..P_TICKS-1 every clock, independent of O_ready.
  - cyc = (tick == 0). Every state/counter update happens only on clocks with cyc = 1; that clock is the CPU-cycle boundary.
  - parity toggles each cyc; 0 = get cycle, 1 = put cycle.
- **State machine** (registered, encoded in the package): IDLE, HALT, ALIGN, READ, WRITE.
  - IDLE: on cyc with I_cpu_addr == P_TRIGGER_ADDR and I_cpu_rdwr == 0:
    - page ← I_cpu_wr_data;
    - cnt ← 0;
    - → HALT.
  - HALT: one cycle. Next state is ALIGN if the parity being entered is 1, otherwise READ.
  - ALIGN: one cycle → READ.
  - READ: O_addr = {page, cnt}, O_rdwr = 1. At cyc: buf ← I_rd_data, → WRITE.
  - WRITE: O_addr = P_DEST_ADDR, O_wr_data = buf, O_rdwr = 0. At cyc:
    - cnt == 255 → IDLE;
    - otherwise cnt ← cnt + 1, → READ.
- **Bus mux**
  - IDLE: O_addr/O_wr_data/O_rdwr pass through the core outputs.
  - HALT/ALIGN: O_addr = I_cpu_addr with O_rdwr forced to 1, a dummy read. A pending core write is never issued.
- **Outputs**
  - O_ready = (state == IDLE), registered.
  - O_busy = ~O_ready.
- **Arithmetic**
  - cnt is 8 bits. The source address never carries into the next page: page FF reads FF00–FFFF.
  - Source and destination addresses are not checked; a trigger page of 20 reads PPU registers.
- **Boundary cases**
  - A trigger cannot recur while busy, because the core is stalled. Triggers are ignored outside IDLE.
  - Core reads of P_TRIGGER_ADDR are ignored.
  - Reset mid-transfer aborts at once. The next transfer restarts from cnt 0.

## Timing
- Reset values:
  - tick 0, parity 0, state IDLE;
  - cnt, page, buf all 0;
  - O_ready 1, O_busy 0, O_phy2 0;
  - O_addr/O_wr_data/O_rdwr equal the core pass-through.
- Stall length from the end of the trigger write cycle: 513 cycles (even entry) or 514 cycles (odd entry). That is 513·P_TICKS or 514·P_TICKS clocks.
- O_ready falls on the clock after the trigger cycle's cyc. It rises on the clock after the final WRITE's cyc.
- Stall length is a whole number of CPU cycles, so core and master tick stay phase-aligned after release.
- Bus outputs change only the clock after cyc and are stable for the full cycle.

## Structure
- Package oam_dma_pkg holds:
  - state typedef (dma_state_type);
  - P_TRIGGER_ADDR and P_DEST_ADDR defaults;
  - the tick width constant.
- One sub-module, cpu_timebase: tick counter, phy2, cyc strobe and parity, so later blocks (APU frame counter, DMC DMA) can reuse it.

## Test plan
- Trigger write $4014 ← $02 on an even entry. Expect:
  - reads $0200..$02FF alternating with writes to $2004 carrying the same bytes in order;
  - O_ready low for exactly 513 cycles.
- Same trigger on an odd entry: exactly one ALIGN dummy read; stall of 514 cycles.
- Page $FF: last read address is $FFFF, followed by IDLE. No $0000 access occurs.
- Reset pulse at byte 100: outputs return to reset values at once. A new $4014 ← $03 reads from $0300.
- Core read of $4014, or write of $4015: no stall, O_busy stays 0, pass-through unchanged.
